// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator frame sequencer:
//   - opcode encodings driven onto the unit-select mux
//   - status byte bit positions of the response frame
//   - command / response frame lengths in bytes
//   - sequencer state type
//   - opcode legality helper
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int unsigned STAT_DBZ   = 0;
    localparam int unsigned STAT_BADOP = 1;

    localparam int unsigned CMD_LEN = 5;
    localparam int unsigned RSP_LEN = 5;

    typedef enum logic [1:0] {
        RX     = 2'd0,
        SETTLE = 2'd1,
        TX     = 2'd2
    } seq_state_e;

    // Only 0x00..0x03 select a real arithmetic unit.
    function automatic logic is_legal_op(input logic [7:0] opcode);
        return (opcode[7:2] == 6'b000000);
    endfunction

endpackage

// File: rtl/calc_frame_sequencer_byte_serializer.sv
// ---------------------------------------------------------------------------
// byte_serializer
// Loads a 40-bit frame and shifts it out MSB byte first over a valid/ready
// byte link. tx_data and tx_valid come straight from registers.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load, load_data   capture a new 40-bit frame (starts presenting byte 0)
//   tx_data, tx_valid outbound byte and its valid
//   tx_ready          link accepts the byte
//   done              pulses in the cycle the last byte is accepted
// ---------------------------------------------------------------------------
module byte_serializer
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [39:0] load_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam logic [2:0] LAST_IDX = 3'(RSP_LEN - 1);

    logic [39:0] shift_r;
    logic [2:0]  cnt_r;
    logic        valid_r;
    logic        fire_s;

    // Handshake decode for the byte currently presented.
    always_comb begin
        fire_s = valid_r & tx_ready;
        if (fire_s && (cnt_r == LAST_IDX)) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
    end

    // Shift register: zeros fill in behind, so tx_data idles at 0 after a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= 40'h00_0000_0000;
            cnt_r   <= 3'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shift_r <= load_data;
            cnt_r   <= 3'd0;
            valid_r <= 1'b1;
        end else if (fire_s) begin
            shift_r <= {shift_r[31:0], 8'h00};
            if (cnt_r == LAST_IDX) begin
                cnt_r   <= 3'd0;
                valid_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_r + 3'd1;
            end
        end
    end

    assign tx_data  = shift_r[39:32];
    assign tx_valid = valid_r;

endmodule

// File: rtl/calc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// calc_frame_sequencer
// Assembles a 5-byte command frame (opcode, P hi, P lo, Q hi, Q lo), holds the
// opcode/operands on the arithmetic unit inputs, waits SETTLE_CYCLES, captures
// the unit result and divide-by-zero flag, then streams a 5-byte response
// (status, result MSB..LSB).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready  inbound command byte link
//   op_sel, op_p, op_q         registered unit select and operands
//   res_in, dbz_in             muxed unit result and divider zero flag
//   tx_data/tx_valid/tx_ready  outbound response byte link
//   busy                       frame in progress
// ---------------------------------------------------------------------------
module calc_frame_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [1:0]  op_sel,
    output logic [15:0] op_p,
    output logic [15:0] op_q,
    input  logic [31:0] res_in,
    input  logic        dbz_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    localparam logic [2:0] RX_LAST     = 3'(CMD_LEN - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    seq_state_e  state_r;
    logic [2:0]  rx_cnt_r;
    logic [3:0]  settle_cnt_r;
    logic        rx_ready_r;
    logic        busy_r;
    logic        bad_op_r;
    logic [1:0]  op_sel_r;
    logic [15:0] op_p_r;
    logic [15:0] op_q_r;

    logic        rx_fire_s;
    logic        capture_s;
    logic        dbz_s;
    logic [31:0] res_s;
    logic [7:0]  status_s;
    logic [39:0] frame_s;
    logic        tx_done_s;

    // Capture-time result shaping: dbz only counts for a divide, and any
    // error zeroes the result so the host never sees garbage.
    always_comb begin
        rx_fire_s = rx_valid & rx_ready_r;
        capture_s = (state_r == SETTLE) && (settle_cnt_r == SETTLE_LAST);
        if (op_sel_r == OP_DIV) begin
            dbz_s = dbz_in;
        end else begin
            dbz_s = 1'b0;
        end
        if (bad_op_r || dbz_s) begin
            res_s = 32'h0000_0000;
        end else begin
            res_s = res_in;
        end
        status_s             = 8'h00;
        status_s[STAT_BADOP] = bad_op_r;
        status_s[STAT_DBZ]   = dbz_s;
        frame_s              = {status_s, res_s};
    end

    // Sequencer FSM, byte-wise operand assembly and handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= RX;
            rx_cnt_r     <= 3'd0;
            settle_cnt_r <= 4'd0;
            rx_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            bad_op_r     <= 1'b0;
            op_sel_r     <= OP_ADD;
            op_p_r       <= 16'h0000;
            op_q_r       <= 16'h0000;
        end else begin
            case (state_r)
                RX: begin
                    rx_ready_r <= 1'b1;
                    if (rx_fire_s) begin
                        busy_r <= 1'b1;
                        case (rx_cnt_r)
                            3'd0: begin
                                // Illegal opcodes park the mux on add and flag the frame.
                                bad_op_r <= !is_legal_op(rx_data);
                                op_sel_r <= is_legal_op(rx_data) ? rx_data[1:0] : OP_ADD;
                            end
                            3'd1:    op_p_r[15:8] <= rx_data;
                            3'd2:    op_p_r[7:0]  <= rx_data;
                            3'd3:    op_q_r[15:8] <= rx_data;
                            3'd4:    op_q_r[7:0]  <= rx_data;
                            default: op_q_r       <= op_q_r;
                        endcase
                        if (rx_cnt_r == RX_LAST) begin
                            rx_cnt_r     <= 3'd0;
                            rx_ready_r   <= 1'b0;
                            settle_cnt_r <= 4'd0;
                            state_r      <= SETTLE;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 3'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (capture_s) begin
                        settle_cnt_r <= 4'd0;
                        state_r      <= TX;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                TX: begin
                    if (tx_done_s) begin
                        rx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= RX;
                    end
                end
                default: begin
                    state_r    <= RX;
                    rx_cnt_r   <= 3'd0;
                    rx_ready_r <= 1'b0;
                end
            endcase
        end
    end

    byte_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture_s),
        .load_data (frame_s),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (tx_done_s)
    );

    assign rx_ready = rx_ready_r;
    assign busy     = busy_r;
    assign op_sel   = op_sel_r;
    assign op_p     = op_p_r;
    assign op_q     = op_q_r;

endmodule

// File: tb/tb_calc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for calc_frame_sequencer. A small behavioural
// model of the arithmetic units drives res_in/dbz_in from op_sel/op_p/op_q;
// every expected response is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_calc_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  op_sel;
    logic [15:0] op_p;
    logic [15:0] op_q;
    logic [31:0] res_in;
    logic        dbz_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    calc_frame_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .op_sel   (op_sel),
        .op_p     (op_p),
        .op_q     (op_q),
        .res_in   (res_in),
        .dbz_in   (dbz_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic units + result mux model. Divide by zero returns junk that
    // the sequencer must suppress.
    always_comb begin
        dbz_in = 1'b0;
        case (op_sel)
            2'd0: res_in = {16'h0000, op_p} + {16'h0000, op_q};
            2'd1: res_in = {16'h0000, op_p} - {16'h0000, op_q};
            2'd2: res_in = 32'(op_p) * 32'(op_q);
            default: begin
                if (op_q == 16'h0000) begin
                    res_in = 32'hFFFF_FFFF;
                    dbz_in = 1'b1;
                end else begin
                    res_in = {16'h0000, op_p / op_q};
                end
            end
        endcase
    end

    // Drives a command frame; called and returns at a negedge.
    task automatic send_frame(input logic [39:0] frame, input int gap_max,
                              output bit ok, output int last_cyc);
        ok = 1'b1;
        last_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            int gap;
            bit got;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frame[39 - 8*i -: 8];
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                if (rx_ready === 1'b1) begin
                    got = 1'b1;
                    last_cyc = cyc;
                end
                @(negedge clk);
            end
            if (!got) ok = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    // Collects a response frame with optional backpressure; optionally keeps
    // rx_valid asserted with junk while the sequencer is not accepting.
    task automatic recv_frame(input int stall_first, input bit rand_stall, input bit junk_rx,
                              output logic [39:0] rsp, output bit ok, output bit stable,
                              output int first_cyc);
        int n;
        int stalls;
        bit have_held;
        bit rdy;
        logic [7:0] held;
        n = 0;
        stalls = 0;
        have_held = 1'b0;
        held = 8'h00;
        rsp = 40'h0;
        stable = 1'b1;
        first_cyc = -1;
        if (junk_rx) begin
            rx_valid = 1'b1;
            rx_data  = 8'hAA;
        end
        for (int t = 0; t < 300 && n < 5; t++) begin
            rdy = 1'b0;
            if (tx_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (have_held && tx_data !== held) stable = 1'b0;
                if (n == 0 && stalls < stall_first) begin
                    rdy = 1'b0;
                    stalls++;
                end else if (rand_stall) begin
                    rdy = ($urandom_range(0, 1) == 1);
                end else begin
                    rdy = 1'b1;
                end
                if (rdy) begin
                    rsp = {rsp[31:0], tx_data};
                    n++;
                    have_held = 1'b0;
                    if (n == 5) rx_valid = 1'b0;
                end else begin
                    held = tx_data;
                    have_held = 1'b1;
                end
            end
            tx_ready = rdy;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        ok = (n == 5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, tx_data, busy, op_sel, op_p, op_q} !== 45'h0) begin
            failures++;
            $display("FAIL reset_values: got rdy=%b txv=%b txd=%h busy=%b sel=%h p=%h q=%h, want all 0",
                     rx_ready, tx_valid, tx_data, busy, op_sel, op_p, op_q);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rx_ready: got %b want 1", rx_ready);
        end
    endtask

    task automatic test_div();
        bit ok; bit ok2; bit st; int last; int first; logic [39:0] rsp;
        send_frame(40'h03_0064_0007, 0, ok, last);
        checks++;
        if (!ok || op_sel !== 2'd3 || op_p !== 16'h0064 || op_q !== 16'h0007 || busy !== 1'b1) begin
            failures++;
            $display("FAIL div_operands: ok=%b sel=%h p=%h q=%h busy=%b want 1/3/0064/0007/1",
                     ok, op_sel, op_p, op_q, busy);
        end
        recv_frame(0, 1'b0, 1'b0, rsp, ok2, st, first);
        checks++;
        if (!ok2 || rsp !== 40'h00_0000_000E) begin
            failures++;
            $display("FAIL div_response: ok=%b got %h want 000000000e", ok2, rsp);
        end
        checks++;
        if (first - last !== 3) begin
            failures++;
            $display("FAIL div_latency: got %0d want 3", first - last);
        end
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL div_frame_end: txv=%b rdy=%b busy=%b want 0/1/0", tx_valid, rx_ready, busy);
        end
    endtask

    task automatic test_div_by_zero();
        bit ok; bit ok2; bit st; int last; int first; logic [39:0] rsp;
        send_frame(40'h03_1234_0000, 0, ok, last);
        recv_frame(0, 1'b0, 1'b0, rsp, ok2, st, first);
        checks++;
        if (!ok || !ok2 || rsp !== 40'h01_0000_0000) begin
            failures++;
            $display("FAIL dbz_response: ok=%b/%b got %h want 0100000000", ok, ok2, rsp);
        end
    endtask

    task automatic test_bad_opcode();
        bit ok; bit ok2; bit st; int last; int first; logic [39:0] rsp;
        send_frame(40'h07_0001_0001, 0, ok, last);
        checks++;
        if (!ok || op_sel !== 2'd0) begin
            failures++;
            $display("FAIL badop_sel: ok=%b sel=%h want 0", ok, op_sel);
        end
        recv_frame(0, 1'b0, 1'b0, rsp, ok2, st, first);
        checks++;
        if (!ok2 || rsp !== 40'h02_0000_0000) begin
            failures++;
            $display("FAIL badop_response: ok=%b got %h want 0200000000", ok2, rsp);
        end
    endtask

    task automatic test_backpressure();
        bit ok; bit ok2; bit st; int last; int first; logic [39:0] rsp;
        send_frame(40'h02_0100_0100, 0, ok, last);
        recv_frame(4, 1'b1, 1'b0, rsp, ok2, st, first);
        checks++;
        if (!ok || !ok2 || rsp !== 40'h00_0001_0000) begin
            failures++;
            $display("FAIL bp_response: ok=%b/%b got %h want 0000010000", ok, ok2, rsp);
        end
        checks++;
        if (st !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: tx_data changed while stalled, got %b want 1", st);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; bit ok2; bit st; bit quiet; int last; int first; logic [39:0] rsp;
        rx_valid = 1'b1;
        rx_data = 8'h02;
        @(negedge clk);
        rx_data = 8'h11;
        @(negedge clk);
        rx_data = 8'h22;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || op_p !== 16'h1122) begin
            failures++;
            $display("FAIL midframe_partial: busy=%b p=%h want 1/1122", busy, op_p);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_ready, tx_valid, tx_data, busy, op_sel, op_p, op_q} !== 45'h0) begin
            failures++;
            $display("FAIL midframe_reset_values: rdy=%b txv=%b txd=%h busy=%b sel=%h p=%h q=%h want all 0",
                     rx_ready, tx_valid, tx_data, busy, op_sel, op_p, op_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(40'h00_0005_0003, 0, ok, last);
        recv_frame(0, 1'b0, 1'b0, rsp, ok2, st, first);
        checks++;
        if (!ok || !ok2 || rsp !== 40'h00_0000_0008) begin
            failures++;
            $display("FAIL midframe_add_response: ok=%b/%b got %h want 0000000008", ok, ok2, rsp);
        end
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL midframe_single_response: extra tx_valid seen, got %b want 1", quiet);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; bit ok2; bit st; int last; int first; logic [39:0] rsp;
        send_frame(40'h01_000A_0004, 3, ok, last);
        recv_frame(0, 1'b0, 1'b1, rsp, ok2, st, first);
        checks++;
        if (!ok || !ok2 || rsp !== 40'h00_0000_0006) begin
            failures++;
            $display("FAIL b2b_first: ok=%b/%b got %h want 0000000006", ok, ok2, rsp);
        end
        send_frame(40'h01_0004_000A, 3, ok, last);
        checks++;
        if (!ok || op_p !== 16'h0004 || op_q !== 16'h000A || op_sel !== 2'd1) begin
            failures++;
            $display("FAIL b2b_second_operands: ok=%b sel=%h p=%h q=%h want 1/1/0004/000a",
                     ok, op_sel, op_p, op_q);
        end
        recv_frame(0, 1'b0, 1'b1, rsp, ok2, st, first);
        checks++;
        if (!ok2 || rsp !== 40'h00_FFFF_FFFA) begin
            failures++;
            $display("FAIL b2b_second: ok=%b got %h want 00fffffffa", ok2, rsp);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_div_by_zero();
        test_bad_opcode();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_frame_sequencer.md
# calc_frame_sequencer

Byte-serial command sequencer between the Python middleware link and the calculator's combinational arithmetic units (add, sub, mul, division). It assembles a 5-byte command frame into an opcode and two 16-bit operands and holds them stable on the unit inputs. After a settle interval it captures the 32-bit result and the divide-by-zero flag, then streams a 5-byte response frame back to the link.

## Interface
- `SETTLE_CYCLES`, default 2: cycles operands are held before result capture; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  inbound frame byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  sequencer accepts a byte this cycle.
- `op_sel`  out  2  unit select to the result mux: 0 add, 1 sub, 2 mul, 3 div.
- `op_p`  out  16  operand P (dividend for div).
- `op_q`  out  16  operand Q (divisor for div).
- `res_in`  in  32  muxed result from the selected unit.
- `dbz_in`  in  1  divide-by-zero flag from the division unit.
- `tx_data`  out  8  outbound response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  link accepts the byte.
- `busy`  out  1  high from first accepted byte until last response byte is accepted.

## Operation
- Command frame, in order: opcode, P[15:8], P[7:0], Q[15:8], Q[7:0].
  - Legal opcodes: 0x00–0x03, mapped to `op_sel`.
  - Any other opcode sets `bad_op`. The frame is still fully consumed, and `op_sel` is held at 0.
- FSM states:
  - RX: byte counter 0..4. Exits to SETTLE after byte 4 is accepted.
  - SETTLE: counter 0..SETTLE_CYCLES-1. Exits to TX on the last count.
  - TX: byte counter 0..4. Returns to RX after byte 4 is accepted.
- Operand registers load byte-wise as bytes are accepted. `op_sel`, `op_p` and `op_q` are registered and unchanged from the end of RX until the next frame's bytes arrive.
- Capture, at the last SETTLE edge:
  - `res_q` = `res_in`.
  - `dbz_q` = `dbz_in` when `op_sel`==3, otherwise 0.
  - If `bad_op` or `dbz_q` is set, `res_q` is forced to 0.
- Response frame, in order:
  - Status byte {6'b0, `bad_op`, `dbz_q`}.
  - Then `res_q[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
- Result arithmetic is done entirely in the units. The sequencer does no width conversion; `res_in` is passed through unchanged.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `op_sel`=0, `op_p`=0, `op_q`=0, internal `res_q`/`dbz_q`/`bad_op`=0. State RX, counters 0.
- `rx_ready` is 1 in RX from the first cycle after reset deasserts. It is 0 in SETTLE and TX.
- A byte transfers when `rx_valid`&`rx_ready` is sampled high. Gaps in `rx_valid` are allowed; there is no timeout.
- TX handshake:
  - `tx_valid` rises the cycle after the last SETTLE cycle.
  - `tx_data` is held stable while `tx_valid`&!`tx_ready`.
  - A byte transfers on `tx_valid`&`tx_ready`. The next byte is presented the following cycle, with `tx_valid` staying high through the frame.
  - After the 5th transfer, `tx_valid` goes to 0 and `rx_ready` to 1 in the same next cycle.
- Latency with no backpressure and no input gaps: last command byte accepted at cycle N, status byte presented at N+SETTLE_CYCLES+1, last response byte accepted at N+SETTLE_CYCLES+5.
- `rst_n` low mid-frame (any state): all state returns to reset values on that edge. A partial frame is discarded and a pending response is dropped.
- `rx_valid` high during SETTLE or TX is ignored; no bytes are lost because `rx_ready`=0.

## Structure
- Shared package `calc_pkg` holds:
  - Opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - Status bit positions STAT_DBZ=0, STAT_BADOP=1.
  - Frame lengths CMD_LEN=5, RSP_LEN=5.
  - The state enum {RX, SETTLE, TX}.
- One sub-module, `byte_serializer`: a 40-bit load, 8-bit valid/ready shift-out, used for the TX path. RX assembly stays inline.

## Test plan
- Div: frame 03 00 64 00 07, SETTLE_CYCLES=2 -> `op_p`=0x0064, `op_q`=0x0007. Response 00 00 00 00 0E; status byte appears 3 cycles after the last command byte.
- Divide by zero: frame 03 12 34 00 00, divider drives `dbz_in`=1 -> response 01 00 00 00 00.
- Bad opcode: frame 07 00 01 00 01 -> response 02 00 00 00 00 and `op_sel`=0.
- Backpressure: mul 02 01 00 01 00, `tx_ready` low for 4 cycles on the status byte and randomly thereafter -> bytes 00 00 01 00 00 in order, `tx_data` stable while stalled.
- Reset mid-frame: `rst_n` low after 3 command bytes, then a full add frame 00 00 05 00 03 -> single response 00 00 00 00 08, with outputs at reset values during reset.
- Back-to-back frames with `rx_valid` gaps of 0–3 cycles: two sub frames 01 00 0A 00 04 and 01 00 04 00 0A -> responses 00 00 00 00 06 and 00 FF FF FF FA.
